i2c_arbiter: RTL and testbench

Shares one `i2c_master` instance among N_REQ independent requesters, such as a temperature poller, a config writer and a debug port, on the Nexys 4 board. It grants the bus round-robin, one whole transaction at a time, and latches the granted requester's transaction descriptor. It drives the master's request handshake, routes read data, chunk requests and completion/error status back to the owning requester, and aborts launches the master never accepts.

---
 rtl/i2c_arbiter.sv | 106 ++++++++++
 tb/tb_i2c_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/i2c_arbiter.sv
// i2c_arbiter: round-robin sharing of one i2c_master among N_REQ requesters, one whole transaction per grant.
module i2c_arbiter #(
  parameter int N_REQ = 4,
  parameter int LAUNCH_TIMEOUT = 1000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req,
  input  logic [8*N_REQ-1:0]  cl_addr_w_rw,
  input  logic [16*N_REQ-1:0] cl_sub_addr,
  input  logic [N_REQ-1:0]    cl_sub_len,
  input  logic [24*N_REQ-1:0] cl_byte_len,
  input  logic [8*N_REQ-1:0]  cl_data_write,
  output logic [N_REQ-1:0]    gnt,
  output logic [7:0]          cl_data_out,
  output logic [N_REQ-1:0]    cl_valid_out,
  output logic [N_REQ-1:0]    cl_req_data_chunk,
  output logic [N_REQ-1:0]    done,
  output logic [N_REQ-1:0]    err,
  output logic [7:0]          m_addr_w_rw,
  output logic [15:0]         m_sub_addr,
  output logic                m_sub_len,
  output logic [23:0]         m_byte_len,
  output logic [7:0]          m_data_write,
  output logic                m_req_trans,
  input  logic [7:0]          m_data_out,
  input  logic                m_valid_out,
  input  logic                m_req_data_chunk,
  input  logic                m_busy,
  input  logic                m_nack
);
  localparam int PW = $clog2(N_REQ);
  localparam int WW = $clog2(LAUNCH_TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, LAUNCH, ACTIVE, FINISH} state_t;
  state_t state, state_n;
  logic [PW-1:0] ptr, ptr_n, own, own_n, pick;
  logic [WW-1:0] wd, wd_n;
  logic nack_seen, nack_n, load;
  always_comb begin
    pick = '0;
    for (int k = N_REQ - 1; k >= 0; k--)
      if (req[PW'((int'(ptr) + k) % N_REQ)]) pick = PW'((int'(ptr) + k) % N_REQ);
  end
  always_comb begin
    state_n = state;
    ptr_n = ptr;
    own_n = own;
    wd_n = wd;
    nack_n = nack_seen;
    load = 1'b0;
    case (state)
      IDLE: if (|req) begin
        state_n = LAUNCH;
        own_n = pick;
        ptr_n = (pick == PW'(N_REQ - 1)) ? '0 : pick + 1'b1;
        wd_n = '0;
        nack_n = 1'b0;
        load = 1'b1;
      end
      LAUNCH: if (m_busy) state_n = ACTIVE;
        else if (wd == WW'(LAUNCH_TIMEOUT - 1)) begin
          state_n = FINISH;
          nack_n = 1'b1;
        end else wd_n = wd + 1'b1;
      ACTIVE: begin
        if (m_busy && m_nack) nack_n = 1'b1;
        if (!m_busy) state_n = FINISH;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr <= '0;
      own <= '0;
      wd <= '0;
      nack_seen <= 1'b0;
      m_addr_w_rw <= '0;
      m_sub_addr <= '0;
      m_sub_len <= 1'b0;
      m_byte_len <= '0;
    end else begin
      state <= state_n;
      ptr <= ptr_n;
      own <= own_n;
      wd <= wd_n;
      nack_seen <= nack_n;
      if (load) begin
        m_addr_w_rw <= cl_addr_w_rw[{pick, 3'b0} +: 8];
        m_sub_addr <= cl_sub_addr[{pick, 4'b0} +: 16];
        m_sub_len <= cl_sub_len[pick];
        m_byte_len <= cl_byte_len[pick * 24 +: 24];
      end
    end
  end
  // gnt holds through FINISH so the status pulse lands on the owner
  assign gnt = (state == IDLE) ? '0 : N_REQ'(1) << own;
  assign m_req_trans = state == LAUNCH;
  assign done = (state == FINISH && !nack_seen) ? gnt : '0;
  assign err = (state == FINISH && nack_seen) ? gnt : '0;
  assign cl_data_out = m_data_out;
  assign cl_valid_out = {N_REQ{m_valid_out}} & gnt;
  assign cl_req_data_chunk = {N_REQ{m_req_data_chunk}} & gnt;
  assign m_data_write = (state == IDLE) ? '0 : cl_data_write[{own, 3'b0} +: 8];
endmodule

// File: tb/tb_i2c_arbiter.sv
// tb_i2c_arbiter: scoreboard bench with a behavioural i2c_master model driving the arbiter.
module tb_i2c_arbiter;
  localparam int N = 4;
  logic clk = 1'b0, rst;
  logic [N-1:0] req, gnt, cl_valid_out, cl_req_data_chunk, done, err, cl_sub_len;
  logic [8*N-1:0] cl_addr_w_rw, cl_data_write;
  logic [16*N-1:0] cl_sub_addr;
  logic [24*N-1:0] cl_byte_len;
  logic [7:0] cl_data_out, m_addr_w_rw, m_data_write, m_data_out;
  logic [15:0] m_sub_addr;
  logic m_sub_len, m_req_trans, m_valid_out, m_req_data_chunk, m_busy, m_nack;
  logic [23:0] m_byte_len;
  int nvec = 0, nbad = 0;
  logic [N-1:0] gq[$];
  logic [7:0] sq[$];
  logic [11:0] vq[$], wq[$];
  logic [N-1:0] gnt_q = '0;
  always #5 clk = ~clk;
  i2c_arbiter #(.N_REQ(N), .LAUNCH_TIMEOUT(10)) dut (
    .clk(clk), .rst(rst), .req(req), .cl_addr_w_rw(cl_addr_w_rw), .cl_sub_addr(cl_sub_addr),
    .cl_sub_len(cl_sub_len), .cl_byte_len(cl_byte_len), .cl_data_write(cl_data_write),
    .gnt(gnt), .cl_data_out(cl_data_out), .cl_valid_out(cl_valid_out),
    .cl_req_data_chunk(cl_req_data_chunk), .done(done), .err(err),
    .m_addr_w_rw(m_addr_w_rw), .m_sub_addr(m_sub_addr), .m_sub_len(m_sub_len),
    .m_byte_len(m_byte_len), .m_data_write(m_data_write), .m_req_trans(m_req_trans),
    .m_data_out(m_data_out), .m_valid_out(m_valid_out), .m_req_data_chunk(m_req_data_chunk),
    .m_busy(m_busy), .m_nack(m_nack)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (!rst) begin
      if (gnt != '0 && gnt_q == '0) begin
        if (gq.size() == 0) chk("gnt_unexpected", 32'(gnt), 0);
        else chk("gnt", 32'(gnt), 32'(gq.pop_front()));
        chk("gnt_onehot", 32'($onehot(gnt)), 1);
      end
      if ((done | err) != '0) begin
        if (sq.size() == 0) chk("status_unexpected", 32'({err, done}), 0);
        else chk("status", 32'({err, done}), 32'(sq.pop_front()));
      end
      if (cl_valid_out != '0) begin
        if (vq.size() == 0) chk("valid_unexpected", 32'(cl_valid_out), 0);
        else chk("rdata", 32'({cl_valid_out, cl_data_out}), 32'(vq.pop_front()));
      end
      if (cl_req_data_chunk != '0) begin
        if (wq.size() == 0) chk("chunk_unexpected", 32'(cl_req_data_chunk), 0);
        else chk("wdata", 32'({cl_req_data_chunk, m_data_write}), 32'(wq.pop_front()));
      end
    end
    gnt_q <= gnt;
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic setcl(input int i, input logic [7:0] a, input logic [15:0] s, input logic sl, input logic [23:0] bl);
    cl_addr_w_rw[i*8 +: 8] = a;
    cl_sub_addr[i*16 +: 16] = s;
    cl_sub_len[i] = sl;
    cl_byte_len[i*24 +: 24] = bl;
  endtask
  // mode 0 read, 1 write, 2 nack, 3 never busy; returns in the FINISH cycle
  task automatic serve(input int mode, input int nb, input logic [7:0] d0, input int wr_idx);
    int t = 0;
    while (!m_req_trans && t < 50) begin
      tick();
      t++;
    end
    chk("launch_seen", 32'(m_req_trans), 1);
    if (!m_req_trans) return;
    if (mode == 3) begin
      t = 0;
      while (m_req_trans && t < 50) begin
        tick();
        t++;
      end
      chk("launch_len", t, 10);
      return;
    end
    m_busy = 1'b1;
    m_nack = (mode == 0);
    tick();
    chk("req_trans_drop", 32'(m_req_trans), 0);
    m_nack = 1'b0;
    for (int i = 0; i < nb; i++) begin
      if (mode == 0) begin
        m_valid_out = 1'b1;
        m_data_out = d0 + 8'(i);
        tick();
        m_valid_out = 1'b0;
      end else if (mode == 1) begin
        m_req_data_chunk = 1'b1;
        tick();
        m_req_data_chunk = 1'b0;
        cl_data_write[wr_idx*8 +: 8] = 8'h11 * 8'(i + 2);
      end else begin
        m_nack = (i == 0);
        tick();
        m_nack = 1'b0;
      end
    end
    m_busy = 1'b0;
    tick();
  endtask
  initial begin
    rst = 1'b1;
    req = 4'hF;
    {m_data_out, m_valid_out, m_req_data_chunk, m_busy, m_nack} = '0;
    cl_data_write = 32'hA5A5_A5A5;
    for (int i = 0; i < N; i++) setcl(i, 8'(8'h10 + i), 16'(i), 1'b0, 24'd1);
    tick();
    tick();
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_req_trans", 32'(m_req_trans), 0);
    chk("rst_status", 32'({err, done}), 0);
    chk("rst_addr", 32'(m_addr_w_rw), 0);
    chk("rst_len", 32'(m_byte_len), 0);
    chk("rst_mdw", 32'(m_data_write), 0);
    for (int i = 0; i < 5; i++) begin
      gq.push_back(4'b1 << (i % 4));
      sq.push_back(8'(4'b1 << (i % 4)));
    end
    rst = 1'b0;
    for (int i = 0; i < 5; i++) serve(0, 0, 8'h00, 0);
    req = '0;
    tick();
    chk("idle_mdw", 32'(m_data_write), 0);
    setcl(1, 8'h97, 16'h000B, 1'b0, 24'd1);
    gq.push_back(4'b0010);
    vq.push_back({4'b0010, 8'hCB});
    sq.push_back(8'h02);
    req = 4'b0010;
    serve(0, 1, 8'hCB, 0);
    req = '0;
    chk("rd_addr", 32'(m_addr_w_rw), 32'h97);
    chk("rd_sub", 32'(m_sub_addr), 32'h0B);
    chk("rd_sublen", 32'(m_sub_len), 0);
    chk("rd_len", 32'(m_byte_len), 1);
    setcl(2, 8'h96, 16'h1234, 1'b1, 24'd3);
    cl_data_write[16 +: 8] = 8'h11;
    gq.push_back(4'b0100);
    wq.push_back({4'b0100, 8'h11});
    wq.push_back({4'b0100, 8'h22});
    wq.push_back({4'b0100, 8'h33});
    sq.push_back(8'h04);
    req = 4'b0100;
    serve(1, 3, 8'h00, 2);
    req = '0;
    chk("wr_sub", 32'(m_sub_addr), 32'h1234);
    chk("wr_sublen", 32'(m_sub_len), 1);
    chk("wr_len", 32'(m_byte_len), 3);
    gq.push_back(4'b1000);
    sq.push_back(8'h80);
    gq.push_back(4'b0001);
    sq.push_back(8'h01);
    req = 4'b1001;
    serve(2, 2, 8'h00, 0);
    req[3] = 1'b0;
    serve(0, 0, 8'h00, 0);
    req = '0;
    gq.push_back(4'b0100);
    sq.push_back(8'h40);
    req = 4'b0100;
    serve(3, 0, 8'h00, 0);
    req = '0;
    tick();
    tick();
    chk("to_idle_gnt", 32'(gnt), 0);
    gq.push_back(4'b0010);
    req = 4'b0010;
    tick();
    m_busy = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    tick();
    req = '0;
    m_busy = 1'b0;
    chk("mid_rst_gnt", 32'(gnt), 0);
    chk("mid_rst_trans", 32'(m_req_trans), 0);
    chk("mid_rst_status", 32'({err, done}), 0);
    chk("mid_rst_addr", 32'(m_addr_w_rw), 0);
    rst = 1'b0;
    gq.push_back(4'b0001);
    sq.push_back(8'h01);
    gq.push_back(4'b0010);
    sq.push_back(8'h02);
    req = 4'b0011;
    serve(0, 0, 8'h00, 0);
    req[0] = 1'b0;
    serve(0, 0, 8'h00, 0);
    req = '0;
    tick();
    tick();
    chk("gq_empty", gq.size(), 0);
    chk("sq_empty", sq.size(), 0);
    chk("vq_empty", vq.size(), 0);
    chk("wq_empty", wq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule
